alu_rmw_seq: RTL and testbench
==============================

ALU_RMW_SEQ -- requirements
Module: alu_rmw_seq

Interface
REQ-001 clk  in  1  system clock; all state changes on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request to run one read-modify-write operation; sampled only when busy=0.
REQ-004 op  in  4  ALU operation code from the shared OP_* set.
REQ-005 addr  in  16  operand address.
REQ-006 sr_in  in  8  current processor status, captured at start.
REQ-007 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 err  out  1  one-cycle pulse when start carries an unsupported op.
REQ-010 result  out  8  value written back; holds until the next accepted start.
REQ-011 sr_out  out  8  merged status; holds until the next accepted start.
REQ-012 mem_addr/mem_rd/mem_wr  out  16/1/1  memory request; mem_rd and mem_wr are never both high.
REQ-013 mem_wdata  out  8  write data; mem_rdata  in  8  read data; mem_ack  in  1  completes the current request in the same cycle.
REQ-014 alu_op  out  4  and alu_arg  out  8  drive the ALU; alu_data  in  8  and alu_sr  in  8  are ALU results.

Function
REQ-015 States: IDLE, READ, EXEC, DUMMY_WR, WRITE, DONE.
REQ-016 Supported ops: ASL, LSR, ROL, ROR, INC, DEC. Any other op with start in IDLE pulses err next cycle, with no bus activity, and the block stays IDLE.
REQ-017 IDLE: a supported start latches op, addr and sr_in, and enters READ.
REQ-018 READ: mem_rd=1 and mem_addr=addr; hold until mem_ack; on ack, capture mem_rdata as operand and go to EXEC.
REQ-019 EXEC: exactly one cycle; alu_op=latched op and alu_arg=operand; capture alu_data and alu_sr at the closing edge.
REQ-020 Outside EXEC, alu_op = OP_TST.
REQ-021 DUMMY_WR (macro only): mem_wr=1 with mem_wdata=original operand; hold until mem_ack.
REQ-022 WRITE: mem_wr=1 with mem_wdata=result; hold until mem_ack, then go to DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 Status merge for INC/DEC: N and Z come from alu_sr; all other bits come from the latched sr_in.
REQ-025 Status merge for shifts/rotates: N, Z and C come from alu_sr; V and bits 5..2 come from the latched sr_in.
REQ-026 Minimum latency, with mem_ack tied high: start edge to done = 5 cycles with the macro, 4 without.
REQ-027 start while busy=1 is ignored and does not queue.
REQ-028 mem_ack outside READ/DUMMY_WR/WRITE is ignored.
REQ-029 Address 0xFFFF is legal; no wrap logic is applied.

Reset
REQ-030 On reset: state=IDLE; busy, done, err, mem_rd and mem_wr = 0; result, sr_out and mem_wdata = 0x00; mem_addr = 0x0000.
REQ-031 Reset mid-operation aborts immediately: no further bus request is issued and no done pulse is produced.

Configuration
REQ-032 The macro RMW_DUMMY_WR_EN, when defined, inserts DUMMY_WR between EXEC and WRITE, giving NMOS-6502 double-write behaviour.
REQ-033 When RMW_DUMMY_WR_EN is undefined, EXEC goes directly to WRITE and only one write occurs per operation.

Structure
REQ-034 The OP_* codes and SR_* bit indices come from the existing shared k6502_defs include.
REQ-035 The state encoding constants (RMW_ST_*) are added to that same shared defs file.
REQ-036 The ALU is instantiated externally, and this block contains no sub-modules.

Verification
REQ-037 INC, addr=0x0200, rdata=0xFF, sr_in=0x01, ack high: write 0x00 to 0x0200; sr_out=0x03; done at cycle 4 (no macro).
REQ-038 ASL, rdata=0x80, sr_in=0x00: result=0x00; sr_out=0x03 (C=1, Z=1); with the macro, writes 0x80 then 0x00.
REQ-039 ROR, rdata=0x01, sr_in=0x41: result=0x80; sr_out=0xC1 (V preserved).
REQ-040 LSR with mem_ack delayed 3 cycles per request: mem_rd/mem_wr and mem_addr held stable throughout; a start pulsed mid-op is ignored; done fires exactly once.
REQ-041 AND op with start: err pulse; mem_rd and mem_wr stay 0; busy stays 0.
REQ-042 Reset asserted during WRITE: mem_wr=0 on the next cycle, no done pulse, outputs at reset values, and a new INC completes normally afterwards.

Source files
------------

// File: rtl/alu_rmw_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_rmw_seq_pkg : shared k6502 ALU op codes, status bits and RMW state codes
// Revision        : 1.0
// ----------------------------------------------------------------------------
package alu_rmw_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ORA  = 4'h0;
  localparam logic [OP_W-1:0] OP_AND  = 4'h1;
  localparam logic [OP_W-1:0] OP_EOR  = 4'h2;
  localparam logic [OP_W-1:0] OP_ADC  = 4'h3;
  localparam logic [OP_W-1:0] OP_CMP  = 4'h4;
  localparam logic [OP_W-1:0] OP_SBC  = 4'h5;
  localparam logic [OP_W-1:0] OP_ASL  = 4'h6;
  localparam logic [OP_W-1:0] OP_ROL  = 4'h7;
  localparam logic [OP_W-1:0] OP_LSR  = 4'h8;
  localparam logic [OP_W-1:0] OP_ROR  = 4'h9;
  localparam logic [OP_W-1:0] OP_INC  = 4'hA;
  localparam logic [OP_W-1:0] OP_DEC  = 4'hB;
  localparam logic [OP_W-1:0] OP_TST  = 4'hC;
  localparam logic [OP_W-1:0] OP_BIT  = 4'hD;
  localparam logic [OP_W-1:0] OP_PASS = 4'hE;
  localparam logic [OP_W-1:0] OP_NOP  = 4'hF;

  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_I = 2;
  localparam int SR_D = 3;
  localparam int SR_B = 4;
  localparam int SR_U = 5;
  localparam int SR_V = 6;
  localparam int SR_N = 7;

  localparam logic [7:0] SR_MASK_NZ  = (8'h01 << SR_N) | (8'h01 << SR_Z);
  localparam logic [7:0] SR_MASK_NZC = SR_MASK_NZ | (8'h01 << SR_C);

  localparam logic [2:0] RMW_ST_IDLE     = 3'd0;
  localparam logic [2:0] RMW_ST_READ     = 3'd1;
  localparam logic [2:0] RMW_ST_EXEC     = 3'd2;
  localparam logic [2:0] RMW_ST_DUMMY_WR = 3'd3;
  localparam logic [2:0] RMW_ST_WRITE    = 3'd4;
  localparam logic [2:0] RMW_ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = RMW_ST_IDLE,
    ST_READ     = RMW_ST_READ,
    ST_EXEC     = RMW_ST_EXEC,
    ST_DUMMY_WR = RMW_ST_DUMMY_WR,
    ST_WRITE    = RMW_ST_WRITE,
    ST_DONE     = RMW_ST_DONE
  } rmw_state_e;

  function automatic logic is_rmw_op(input logic [OP_W-1:0] op);
    return op inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC};
  endfunction

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return op inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR};
  endfunction

  // Shifts also own carry; INC/DEC leave C with the processor.
  function automatic logic [7:0] sr_merge(input logic [OP_W-1:0] op,
                                          input logic [7:0]      sr_old,
                                          input logic [7:0]      sr_alu);
    logic [7:0] mask;
    mask = is_shift_op(op) ? SR_MASK_NZC : SR_MASK_NZ;
    return (sr_old & ~mask) | (sr_alu & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rmw_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_rmw_seq_if : request, memory and ALU signals of the RMW sequencer
// Revision       : 1.0
// ----------------------------------------------------------------------------
interface alu_rmw_seq_if;
  import alu_rmw_seq_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [15:0]     addr;
  logic [7:0]      sr_in;
  logic            busy;
  logic            done;
  logic            err;
  logic [7:0]      result;
  logic [7:0]      sr_out;
  logic [15:0]     mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem_rdata;
  logic            mem_ack;
  logic [OP_W-1:0] alu_op;
  logic [7:0]      alu_arg;
  logic [7:0]      alu_data;
  logic [7:0]      alu_sr;

  modport master (
    output start, op, addr, sr_in, mem_rdata, mem_ack, alu_data, alu_sr,
    input  busy, done, err, result, sr_out, mem_addr, mem_rd, mem_wr,
           mem_wdata, alu_op, alu_arg
  );

  modport slave (
    input  start, op, addr, sr_in, mem_rdata, mem_ack, alu_data, alu_sr,
    output busy, done, err, result, sr_out, mem_addr, mem_rd, mem_wr,
           mem_wdata, alu_op, alu_arg
  );

endinterface
`default_nettype wire

// File: rtl/alu_rmw_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_rmw_seq : read-modify-write sequencer around an external 6502 ALU.
//               Define RMW_DUMMY_WR_EN for NMOS-style double write.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module alu_rmw_seq
  import alu_rmw_seq_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  alu_rmw_seq_if.slave bus_io
);

  rmw_state_e      state_q,   state_d;
  logic [OP_W-1:0] op_q,      op_d;
  logic [15:0]     addr_q,    addr_d;
  logic [7:0]      sr_q,      sr_d;
  logic [7:0]      operand_q, operand_d;
  logic [7:0]      result_q,  result_d;
  logic [7:0]      sr_out_q,  sr_out_d;
  logic            err_q,     err_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_TST;
      addr_q    <= 16'h0000;
      sr_q      <= 8'h00;
      operand_q <= 8'h00;
      result_q  <= 8'h00;
      sr_out_q  <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      sr_q      <= sr_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      sr_out_q  <= sr_out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    sr_d      = sr_q;
    operand_d = operand_q;
    result_d  = result_q;
    sr_out_d  = sr_out_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          if (is_rmw_op(bus_io.op)) begin
            op_d    = bus_io.op;
            addr_d  = bus_io.addr;
            sr_d    = bus_io.sr_in;
            state_d = ST_READ;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (bus_io.mem_ack) begin
          operand_d = bus_io.mem_rdata;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = bus_io.alu_data;
        sr_out_d = sr_merge(op_q, sr_q, bus_io.alu_sr);
`ifdef RMW_DUMMY_WR_EN
        state_d  = ST_DUMMY_WR;
`else
        state_d  = ST_WRITE;
`endif
      end
      ST_DUMMY_WR: begin
        if (bus_io.mem_ack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus_io.mem_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state register, so a reset
  // drops them on the very next cycle.
  assign bus_io.busy      = (state_q != ST_IDLE);
  assign bus_io.done      = (state_q == ST_DONE);
  assign bus_io.err       = err_q;
  assign bus_io.result    = result_q;
  assign bus_io.sr_out    = sr_out_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_rd    = (state_q == ST_READ);
  assign bus_io.mem_wr    = (state_q == ST_WRITE) || (state_q == ST_DUMMY_WR);
  assign bus_io.mem_wdata = (state_q == ST_DUMMY_WR) ? operand_q : result_q;
  assign bus_io.alu_op    = (state_q == ST_EXEC) ? op_q : OP_TST;
  assign bus_io.alu_arg   = operand_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rmw_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_rmw_seq : self-checking bench for alu_rmw_seq with memory/ALU models
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_alu_rmw_seq;
  import alu_rmw_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_rmw_seq_if rmw();

  alu_rmw_seq dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (rmw)
  );

  int checks;
  int errors;

  // ---------------- memory model: ack after ack_delay waiting cycles
  logic [7:0] mem [0:65535];
  int         ack_delay;
  logic       ack_force;
  int         req_cnt = 0;

  assign rmw.mem_rdata = mem[rmw.mem_addr];
  assign rmw.mem_ack   = ack_force | ((rmw.mem_rd | rmw.mem_wr) && (req_cnt >= ack_delay));

  always @(posedge clk) begin
    if (reset || rmw.mem_ack || !(rmw.mem_rd || rmw.mem_wr)) req_cnt <= 0;
    else                                                     req_cnt <= req_cnt + 1;
  end

  // ---------------- ALU model: byte arithmetic, junk in the bits the DUT must ignore
  logic       cur_cin;
  logic [7:0] junk;
  logic [8:0] alu_t;

  function automatic logic [8:0] calc(input logic [3:0] op, input logic [7:0] a, input logic cin);
    int t;
    int c;
    t = int'(a);
    c = 0;
    case (op)
      OP_ASL: begin t = int'(a) * 2;                 c = t / 256; t = t % 256; end
      OP_ROL: begin t = int'(a) * 2 + int'(cin);     c = t / 256; t = t % 256; end
      OP_LSR: begin c = int'(a) % 2; t = int'(a) / 2; end
      OP_ROR: begin c = int'(a) % 2; t = int'(a) / 2 + 128 * int'(cin); end
      OP_INC: t = (int'(a) + 1) % 256;
      OP_DEC: t = (int'(a) + 255) % 256;
      default: t = int'(a);
    endcase
    return {c[0], t[7:0]};
  endfunction

  assign alu_t        = calc(rmw.alu_op, rmw.alu_arg, cur_cin);
  assign rmw.alu_data = alu_t[7:0];
  assign rmw.alu_sr   = {alu_t[7], junk[6:2], (alu_t[7:0] == 8'h00),
                         (rmw.alu_op inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR}) ? alu_t[8] : junk[0]};

  // ---------------- bus monitor (negedge: all DUT outputs settled)
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          exec_cnt = 0;
  int          rd_cnt   = 0;
  int          bus_err  = 0;
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic        pend = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_rst = 1'b1;
  logic [15:0] p_addr = 16'h0;
  logic [7:0]  p_wdata = 8'h0;

  always @(negedge clk) begin
    if (rmw.done) done_cnt++;
    if (rmw.err) err_cnt++;
    if (rmw.alu_op != OP_TST) exec_cnt++;
    if (rmw.mem_rd && rmw.mem_ack) rd_cnt++;
    if (rmw.mem_wr && rmw.mem_ack) begin
      wr_addr_q.push_back(rmw.mem_addr);
      wr_data_q.push_back(rmw.mem_wdata);
    end
    if (rmw.mem_rd && rmw.mem_wr) bus_err++;
    if (pend && !p_rst && (rmw.mem_rd !== p_rd || rmw.mem_wr !== p_wr ||
                           rmw.mem_addr !== p_addr || rmw.mem_wdata !== p_wdata)) bus_err++;
    pend    = (rmw.mem_rd || rmw.mem_wr) && !rmw.mem_ack;
    p_rd    = rmw.mem_rd;
    p_wr    = rmw.mem_wr;
    p_addr  = rmw.mem_addr;
    p_wdata = rmw.mem_wdata;
    p_rst   = reset;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] sup   [6]  = '{OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC};
  logic [3:0] unsup [10] = '{OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_CMP, OP_SBC,
                             OP_TST, OP_BIT, OP_PASS, OP_NOP};

  // One full operation: drive start, wait for done, compare against the model.
  task automatic run_op(input logic [3:0] op, input logic [15:0] addr, input logic [7:0] rdata,
                        input logic [7:0] sr, input int dly, input bit poke);
    int         base_wr, base_done, base_exec, base_rd, base_err, cyc, exp_lat, exp_nwr, n_wr;
    logic [8:0] t;
    logic [7:0] exp_res, exp_sr;
    t       = calc(op, rdata, sr[0]);
    exp_res = t[7:0];
    exp_sr  = sr;
    exp_sr[7] = exp_res[7];
    exp_sr[1] = (exp_res == 8'h00);
    if (op inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR}) exp_sr[0] = t[8];
`ifdef RMW_DUMMY_WR_EN
    exp_lat = 5 + 3 * dly;
    exp_nwr = 2;
`else
    exp_lat = 4 + 2 * dly;
    exp_nwr = 1;
`endif
    mem[addr] = rdata;
    ack_delay = dly;
    cur_cin   = sr[0];
    junk      = 8'($urandom);
    base_wr = wr_addr_q.size(); base_done = done_cnt; base_exec = exec_cnt;
    base_rd = rd_cnt;           base_err  = err_cnt;

    rmw.start = 1'b1; rmw.op = op; rmw.addr = addr; rmw.sr_in = sr;
    @(posedge clk); #1;
    rmw.start = 1'b0; rmw.op = 4'($urandom); rmw.addr = 16'($urandom); rmw.sr_in = 8'($urandom);
    cyc = 1;
    check("busy_after_start", rmw.busy, 1);
    while (!rmw.done && cyc < 200) begin
      rmw.start = poke && (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    rmw.start = 1'b0;
    check("done_seen", rmw.done, 1);
    check("latency", cyc, exp_lat);
    check("busy_in_done", rmw.busy, 1);
    check("result", rmw.result, exp_res);
    check("sr_out", rmw.sr_out, exp_sr);

    @(posedge clk); #1;
    check("done_one_cycle", rmw.done, 0);
    check("busy_cleared", rmw.busy, 0);
    @(posedge clk); #1;
    check("no_queued_start", rmw.busy, 0);
    check("result_hold", rmw.result, exp_res);
    check("done_count", done_cnt - base_done, 1);
    check("read_count", rd_cnt - base_rd, 1);
    check("exec_cycles", exec_cnt - base_exec, 1);
    check("no_err_pulse", err_cnt - base_err, 0);
    n_wr = wr_addr_q.size() - base_wr;
    check("write_count", n_wr, exp_nwr);
    if (n_wr == exp_nwr) begin
      check("write_addr", wr_addr_q[$], addr);
      check("write_data", wr_data_q[$], exp_res);
`ifdef RMW_DUMMY_WR_EN
      check("dummy_addr", wr_addr_q[base_wr], addr);
      check("dummy_data", wr_data_q[base_wr], rdata);
`endif
    end
  endtask

  task automatic run_err(input logic [3:0] op);
    int base_rd, base_wr, base_err;
    base_rd = rd_cnt; base_wr = wr_addr_q.size(); base_err = err_cnt;
    rmw.op = op; rmw.addr = 16'($urandom); rmw.start = 1'b1;
    @(posedge clk); #1;
    rmw.start = 1'b0;
    check("err_pulse", rmw.err, 1);
    check("err_busy", rmw.busy, 0);
    check("err_no_rd", rmw.mem_rd, 0);
    check("err_no_wr", rmw.mem_wr, 0);
    @(posedge clk); #1;
    check("err_one_cycle", rmw.err, 0);
    check("err_idle", rmw.busy, 0);
    check("err_count", err_cnt - base_err, 1);
    check("err_no_bus", (rd_cnt - base_rd) + (wr_addr_q.size() - base_wr), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_done, base_wr, cyc;
    checks = 0; errors = 0;
    reset = 1'b1; ack_force = 1'b0; ack_delay = 0; cur_cin = 1'b0; junk = 8'h00;
    rmw.start = 1'b0; rmw.op = OP_TST; rmw.addr = 16'h0; rmw.sr_in = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", rmw.busy, 0);
    check("rst_done", rmw.done, 0);
    check("rst_err", rmw.err, 0);
    check("rst_mem_rd", rmw.mem_rd, 0);
    check("rst_mem_wr", rmw.mem_wr, 0);
    check("rst_result", rmw.result, 8'h00);
    check("rst_sr_out", rmw.sr_out, 8'h00);
    check("rst_wdata", rmw.mem_wdata, 8'h00);
    check("rst_addr", rmw.mem_addr, 16'h0000);
    check("rst_alu_op", rmw.alu_op, OP_TST);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-derived results.
    run_op(OP_INC, 16'h0200, 8'hFF, 8'h01, 0, 1'b0);
    check("inc_ff_result", rmw.result, 8'h00);
    check("inc_ff_sr", rmw.sr_out, 8'h03);
    run_op(OP_ASL, 16'h0300, 8'h80, 8'h00, 0, 1'b0);
    check("asl_80_result", rmw.result, 8'h00);
    check("asl_80_sr", rmw.sr_out, 8'h03);
    run_op(OP_ROR, 16'h0400, 8'h01, 8'h41, 0, 1'b0);
    check("ror_01_result", rmw.result, 8'h80);
    check("ror_01_sr", rmw.sr_out, 8'hC1);
    run_op(OP_LSR, 16'h1234, 8'hA5, 8'hFF, 3, 1'b1);
    run_op(OP_DEC, 16'hFFFF, 8'h00, 8'h3C, 1, 1'b0);
    check("bus_stable_directed", bus_err, 0);

    // Unsupported ops, then stray acks while idle.
    run_err(OP_AND);
    for (int i = 0; i < 3; i++) run_err(unsup[$urandom_range(0, 9)]);
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_ack_busy", rmw.busy, 0);
      check("idle_ack_rd", rmw.mem_rd, 0);
    end
    ack_force = 1'b0;

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(sup[$urandom_range(0, 5)], (i == 7) ? 16'hFFFF : 16'($urandom),
             8'($urandom), 8'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset while the write is pending.
    base_done = done_cnt;
    base_wr   = wr_addr_q.size();
    ack_delay = 3;
    mem[16'h0555] = 8'h10;
    cur_cin = 1'b0;
    rmw.op = OP_INC; rmw.addr = 16'h0555; rmw.sr_in = 8'h00; rmw.start = 1'b1;
    @(posedge clk); #1;
    rmw.start = 1'b0;
    cyc = 0;
    while (!rmw.mem_wr && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_write", rmw.mem_wr, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_wr", rmw.mem_wr, 0);
    check("abort_mem_rd", rmw.mem_rd, 0);
    check("abort_busy", rmw.busy, 0);
    check("abort_done", rmw.done, 0);
    check("abort_result", rmw.result, 8'h00);
    check("abort_sr_out", rmw.sr_out, 8'h00);
    check("abort_wdata", rmw.mem_wdata, 8'h00);
    check("abort_addr", rmw.mem_addr, 16'h0000);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_no_write", wr_addr_q.size() - base_wr, 0);
    run_op(OP_INC, 16'h0555, 8'h10, 8'h00, 0, 1'b0);
    check("post_reset_result", rmw.result, 8'h11);

    check("bus_stable_all", bus_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
